bit_serializer: RTL

//  Parallel-to-serial front end that produces the 1-bit stream consumed by the

---
 rtl/serdes_pkg.sv | 15 +
 rtl/bit_serializer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer / detector family: FSM state
// encodings and a named state type used for state display.
package serdes_pkg;

   // FSM encodings used inside the RTL.
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   // Named view of the same encodings for display by downstream users.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } serdes_state_e;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end. WIDTH-bit words arrive over valid/ready and
// are shifted out one bit per ser_en strobe. A one-word holding buffer lets
// the next word follow the current one with no idle bit in between.
//
// Handshake: a word transfers on a rising clk edge where
// data_valid && data_ready. data_ready is !hold_full, taken straight from a
// register, so there is no combinational path from data_valid to data_ready.
// The upstream side holds data_in/data_valid stable until the transfer.
module bit_serializer
   import serdes_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0,
   localparam int  CW        = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic             ser_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic [CW-1:0]    bit_cnt,
   output logic             busy,
   output logic [0:0]       dbg_state
);

   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ser_out_q, ser_out_d;

   logic             accept;
   logic             last_bit;
   logic             word_end;

   // Bit that sits on ser_out when a word occupies the shift register.
   function automatic logic lead_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   assign data_ready = !hold_full_q;
   assign accept     = data_valid && !hold_full_q;
   assign last_bit   = (cnt_q == LAST_IDX);
   // The current word finishes on this edge.
   assign word_end   = (state_q == SHIFT) && ser_en && last_bit;

   // Next-state logic for the FSM, shift register, holding buffer and counter.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            // Buffer is always empty here, so an accepted word goes
            // straight into the shift register and shows its first bit
            // right after this edge. ser_en plays no part in IDLE.
            if (accept) begin
               shift_d = data_in;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_en && !last_bit) begin
               if (MSB_FIRST) begin
                  shift_d = {shift_q[WIDTH-2:0], 1'b0};
               end else begin
                  shift_d = {1'b0, shift_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + CW'(1);
            end else if (word_end) begin
               cnt_d = '0;
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
               end else if (accept) begin
                  // Buffer empty: the arriving word bypasses it.
                  shift_d = data_in;
               end else begin
                  state_d = IDLE;
               end
            end
            // Any other accept parks the word in the holding buffer. An
            // accept implies the buffer was empty, so fill and drain never
            // collide on one edge.
            if (accept && !word_end) begin
               hold_d      = data_in;
               hold_full_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ser_out_d = (state_d == SHIFT) ? lead_bit(shift_d) : IDLE_BIT;
   end

   // State registers; reset discards any word in flight or in the buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
         ser_out_q   <= IDLE_BIT;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
         ser_out_q   <= ser_out_d;
      end
   end

   assign ser_out   = ser_out_q;
   assign ser_valid = (state_q == SHIFT);
   assign bit_cnt   = cnt_q;
   assign busy      = (state_q == SHIFT) || hold_full_q;
   assign dbg_state = state_q;

endmodule
